// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to 3x3 neighbourhood windows, borders dropped
//   clk, rst_n                 clock, async active-low reset
//   s_valid/s_ready/s_data     input pixel stream (raster order)
//   s_sof                      marks pixel (0,0); forces counters on accept
//   m_valid/m_ready/m_pixels   window stream; slot i = 3*row+col, slot 8 = newest pixel
//   m_sof, m_eol               first window of frame, last window of line
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_sof,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [9*DATA_W-1:0] m_pixels,
  output logic                m_sof,
  output logic                m_eol
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  logic [CW-1:0] col, ecol;
  logic [RW-1:0] row, erow;
  logic acc, win;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] rd0, rd1;
  assign s_ready = !m_valid || m_ready;
  assign acc = s_valid && s_ready;
  // an accepted start-of-frame beat is processed as pixel (0,0)
  assign ecol = s_sof ? '0 : col;
  assign erow = s_sof ? '0 : row;
  assign rd1 = lb1[ecol];
  assign rd0 = lb0[ecol];
  assign win = erow >= RW'(2) && ecol >= CW'(2);
  // line buffers are not reset; stale contents only reach windows gated off by row
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[ecol] <= s_data;
      lb0[ecol] <= rd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      m_valid  <= 1'b0;
      m_pixels <= '0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
    end else if (acc) begin
      col      <= ecol == COL_LAST ? '0 : ecol + 1'b1;
      row      <= ecol != COL_LAST ? erow : erow == ROW_LAST ? '0 : erow + 1'b1;
      // shift every window row one column older, new column = {s_data, line r-1, line r-2}
      m_pixels <= {s_data, m_pixels[8*DATA_W +: DATA_W], m_pixels[7*DATA_W +: DATA_W],
                   rd1,    m_pixels[5*DATA_W +: DATA_W], m_pixels[4*DATA_W +: DATA_W],
                   rd0,    m_pixels[2*DATA_W +: DATA_W], m_pixels[1*DATA_W +: DATA_W]};
      m_valid  <= win;
      m_sof    <= win && erow == RW'(2) && ecol == CW'(2);
      m_eol    <= win && ecol == COL_LAST;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of window_3x3_gen on a 4x4 frame, pixel(r,c)=4r+c+1
module tb_window_3x3_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_sof = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [71:0] m_pixels;
  logic        m_sof;
  logic        m_eol;
  logic [73:0] q[$];
  logic        gaps = 1'b0;
  int checks = 0;
  int errors = 0;

  window_3x3_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_pixels(m_pixels),
    .m_sof(m_sof), .m_eol(m_eol)
  );

  always #5 clk = ~clk;

  // handshake signals are stable from negedge to the next posedge, where the transfer happens
  always @(negedge clk) if (m_valid && m_ready) q.push_back({m_pixels, m_sof, m_eol});

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v = '0;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        v[(3*wr+wc)*8 +: 8] = 8'(4*(r-1+wr) + (c-1+wc) + 1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    logic ok = 1'b0;
    s_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data = d;
    s_sof = sof;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      $error("FAIL send_timeout observed=%h expected=%h", d, 1);
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) send(8'(i + 1), i == 0);
  endtask

  task automatic check_windows(input string tag, input int frames);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, 72'(q.size()), 72'(4 * frames));
    for (int k = 0; k < q.size() && k < 4 * frames; k++) begin
      int j = k % 4;
      int r = 1 + j / 2;
      int c = 1 + j % 2;
      chk({tag, "_pix"}, q[k][73:2], exp_win(r, c));
      chk({tag, "_sof"}, 72'(q[k][1]), 72'(j == 0));
      chk({tag, "_eol"}, 72'(q[k][0]), 72'(c == 2));
    end
    q.delete();
  endtask

  initial begin
    #1;
    chk("rst_valid", 72'(m_valid), 72'(0));
    chk("rst_pixels", m_pixels, 72'(0));
    chk("rst_sof_eol", 72'({m_sof, m_eol}), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 1: first window appears right after the 11th accept
    for (int i = 0; i < 10; i++) send(8'(i + 1), i == 0);
    chk("s1_no_early_window", 72'(m_valid), 72'(0));
    send(8'd11, 1'b0);
    chk("s1_first_valid", 72'(m_valid), 72'(1));
    chk("s1_first_pixels", m_pixels, {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1});
    chk("s1_first_sof_eol", 72'({m_sof, m_eol}), 72'(2'b10));
    for (int i = 11; i < 16; i++) send(8'(i + 1), 1'b0);
    // 2: the whole frame yields exactly four windows
    check_windows("s2", 1);
    // 3: downstream stall on the first window
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'(i + 1), i == 0);
    s_valid = 1'b1;
    s_data = 8'd12;
    repeat (5) begin
      @(negedge clk);
      chk("s3_stall_ready", 72'(s_ready), 72'(0));
      chk("s3_stall_pixels", m_pixels, exp_win(1, 1));
      chk("s3_stall_valid", 72'(m_valid), 72'(1));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int i = 11; i < 16; i++) send(8'(i + 1), 1'b0);
    check_windows("s3", 1);
    // 4: random input gaps over three back-to-back frames
    gaps = 1'b1;
    repeat (3) send_frame();
    gaps = 1'b0;
    check_windows("s4", 3);
    // 5: reset in the middle of a frame
    for (int i = 0; i < 9; i++) send(8'(i + 1), i == 0);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 72'(m_valid), 72'(0));
    chk("s5_rst_pixels", m_pixels, 72'(0));
    repeat (2) @(negedge clk);
    chk("s5_rst_held_valid", 72'(m_valid), 72'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    send_frame();
    check_windows("s5", 1);
    // 6: resync on the 7th beat abandons the partial frame
    for (int i = 0; i < 6; i++) send(8'(i + 1), i == 0);
    send_frame();
    check_windows("s6", 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
